ieee488_port: RTL and testbench
===============================

# ieee488_port

Hardware IEEE-488 three-wire handshake engine for the drive side of the emulated 2031/IEEE-488 drive. It replaces per-byte CPU bit-banging of DAV/NRFD/NDAC with a source FSM and an acceptor FSM, each buffered by a parametrised FIFO. It adds automatic ATN acceptance, EOI tagging, a no-listener check and a handshake timeout. Bus-side ports use the existing open-collector convention: 1 = released, 0 = asserted; data is active-low on the bus.

## Interface
Parameters:
- DEPTH, 16: entries per FIFO; power of two, minimum 2.
- SETTLE, 2: ce ticks data/EOI are held on the bus before DAV is asserted.
- TIMEOUT, 4096: ce ticks the source waits in any handshake state before aborting.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  handshake tick; both FSMs and all counters advance only when ce=1.
- talk  in  1  enables the source FSM.
- listen  in  1  enables the acceptor FSM; ATN overrides it.
- tx_data  in  8  byte to send, true polarity.
- tx_eoi  in  1  assert EOI with this byte.
- tx_valid / tx_ready  in / out  1  push handshake; push when both are 1.
- rx_data  out  8  received byte, true polarity.
- rx_eoi  out  1  EOI was asserted with the byte.
- rx_atn  out  1  byte was a command byte (ATN asserted).
- rx_valid / rx_ready  out / in  1  pop handshake.
- ieee_data_i / ieee_data_o  in / out  8  bus data.
- ieee_atn_i, ieee_ifc_i  in  1  bus ATN and IFC.
- ieee_dav_i/o, ieee_eoi_i/o, ieee_nrfd_i/o, ieee_ndac_i/o  in/out  1  handshake lines.
- timeout  out  1  sticky; cleared by reset, IFC or the next successful byte.
- no_listener  out  1  sticky; same clearing rules as timeout.

## Operation
- TX FIFO entries are 9 bits {eoi,data}. RX FIFO entries are 10 bits {atn,eoi,data}. Both FIFOs are first-word-fall-through.
- Source FSM states: S_IDLE, S_WRFD, S_SETTLE, S_DAV, S_DONE.
  - S_IDLE → S_WRFD when talk=1, ATN released and the TX FIFO is non-empty.
  - S_WRFD: drive ~data and EOI. If NRFD and NDAC are both released, set no_listener, release all lines and go to S_IDLE; the byte stays in the FIFO. If NRFD is released and NDAC is asserted, go to S_SETTLE.
  - S_SETTLE: count SETTLE ticks, then go to S_DAV.
  - S_DAV: assert DAV and wait for NDAC released. Then pop the TX FIFO, clear the sticky flags and go to S_DONE.
  - S_DONE: release DAV, data and EOI; go to S_IDLE.
- Acceptor active = listen OR ATN asserted. Acceptor FSM states: A_IDLE, A_RDY, A_ACC, A_WDAVH.
  - A_IDLE: NRFD and NDAC asserted. Go to A_RDY when the RX FIFO is not full.
  - A_RDY: release NRFD. When DAV is asserted, latch {~atn_i, ~eoi_i, ~data_i}, push it and go to A_ACC.
  - A_ACC: assert NRFD, release NDAC, go to A_WDAVH.
  - A_WDAVH: wait for DAV released, assert NDAC, go to A_IDLE.
  - Acceptor inactive: NRFD and NDAC released; FSM held in A_IDLE.
- ATN assertion, sampled on a ce tick:
  - Source aborts to S_IDLE on the same tick and releases DAV, data and EOI; the entry is not popped.
  - Acceptor asserts NDAC on the next ce tick if it was idle-inactive.
- Timeout: a counter runs in S_WRFD and S_DAV and resets on every state change. On reaching TIMEOUT it sets timeout, releases all lines and returns to S_IDLE; the byte is retained.
- IFC asserted acts like reset for both FSMs, both FIFOs and the sticky flags.
- Flag update precedence: reset/IFC, then the ATN abort, then normal transitions.

## Timing
- Reset values:
  - All bus outputs = 1.
  - tx_ready=1, rx_valid=0, rx_data/eoi/atn=0, timeout=0, no_listener=0.
  - Both FIFOs empty; FSMs in S_IDLE / A_IDLE.
- Bus inputs are sampled on ce ticks. Each FSM transition occurs on the tick after its condition is sampled, and outputs are registered. Handshake response latency is therefore exactly 1 ce tick.
- A FIFO push or pop is visible at the FIFO output on the next clk, independent of ce.
- TX full: tx_ready=0. RX full: the acceptor stays in A_IDLE, holding NRFD asserted (flow control).
- Simultaneous push and pop on a full or empty FIFO:
  - Full: the pop happens first, then the push is accepted.
  - Empty: the push is accepted and the pop is ignored.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. Full/empty are decided by comparing the MSBs.
- Best-case source byte time: 1 (WRFD) + SETTLE + 1 (DAV) + 1 (DONE) ticks, plus listener latency.

## Structure
- Package ieee488_pkg holds:
  - the src_state_t and acc_state_t enums;
  - the TX_W=9 and RX_W=10 entry widths;
  - bus polarity constants (REL=1, ASSERT=0).
- Sub-module ieee488_fifo (parameters WIDTH, DEPTH; synchronous FWFT) is instantiated twice.
- The FSMs, timeout counter and settle counter live in ieee488_port.

## Test plan
- Loopback:
  - Stimulus: a model listener; push 0x41, then 0x42 with eoi=1.
  - Response: bus data 0xBE then 0xBD; EOI low only with the second byte; tx_ready stays 1; no flags set.
- No listener:
  - Stimulus: NRFD and NDAC held released; push 0x55.
  - Response: no_listener=1 within 2 ticks; DAV never asserted; the entry remains in the FIFO.
- ATN command receive:
  - Stimulus: listen=0; bus ATN asserted; model talker sends 0x28 (bus 0xD7).
  - Response: rx_data=0x28, rx_atn=1, rx_eoi=0; NDAC asserted 1 tick after ATN.
- ATN abort:
  - Stimulus: assert ATN while the source is in S_DAV.
  - Response: DAV, data and EOI released on the next tick; the entry is resent after ATN is released.
- RX full:
  - Stimulus: DEPTH=4; talker sends 5 bytes; rx_ready=0.
  - Response: the 5th byte is stalled with NRFD held low. After one pop, it is accepted with data intact.
- Timeout and IFC:
  - Stimulus: TIMEOUT=8; NDAC never releases.
  - Response: timeout=1 after 8 ticks in S_DAV. A following IFC pulse clears the flag and empties the FIFOs.

Source files
------------

// File: rtl/ieee488_pkg.sv
// Shared types and constants for the IEEE-488 handshake engine.
// Bus lines are open-collector style: 1 = released, 0 = asserted.
package ieee488_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WRFD, S_SETTLE, S_DAV, S_DONE} src_state_t;
    typedef enum logic [1:0] {A_IDLE, A_RDY, A_ACC, A_WDAVH} acc_state_t;

    localparam int TX_W = 9;
    localparam int RX_W = 10;

    localparam logic REL    = 1'b1;
    localparam logic ASSERT = 1'b0;
endpackage

// File: rtl/ieee488_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB pointers.
// A pop on a full FIFO frees room for a same-cycle push; a pop on empty is ignored.
module ieee488_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/ieee488_port.sv
// IEEE-488 three-wire handshake engine: source FSM and acceptor FSM, each
// buffered by a FIFO, with ATN acceptance, EOI tagging, no-listener and timeout.
//
// state    | meaning
// S_IDLE   | lines released, waiting for talk and a queued byte
// S_WRFD   | data/EOI driven, waiting for NRFD released with NDAC asserted
// S_SETTLE | data held SETTLE ticks before DAV
// S_DAV    | DAV asserted, waiting for NDAC released
// S_DONE   | byte accepted, lines released
// A_IDLE   | NRFD/NDAC asserted; leaves when RX FIFO has room
// A_RDY    | NRFD released, waiting for DAV asserted
// A_ACC    | byte captured, NDAC released
// A_WDAVH  | waiting for DAV released
module ieee488_port
    import ieee488_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       talk,
    input  logic       listen,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    output logic       rx_atn,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] ieee_data_i,
    output logic [7:0] ieee_data_o,
    input  logic       ieee_atn_i,
    input  logic       ieee_ifc_i,
    input  logic       ieee_dav_i,
    output logic       ieee_dav_o,
    input  logic       ieee_eoi_i,
    output logic       ieee_eoi_o,
    input  logic       ieee_nrfd_i,
    output logic       ieee_nrfd_o,
    input  logic       ieee_ndac_i,
    output logic       ieee_ndac_o,
    output logic       timeout,
    output logic       no_listener
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 2);
    localparam logic [TW-1:0] TMO_LOAD    = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE);

    src_state_t      src_state;
    acc_state_t      acc_state;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   settle_cnt;
    logic            ifc, atn, acc_active;
    logic            tx_full, tx_empty, tx_pop;
    logic            rx_full, rx_empty, rx_push;
    logic [TX_W-1:0] tx_head;
    logic [RX_W-1:0] rx_head, rx_word;

    assign ifc        = (ieee_ifc_i == ASSERT);
    assign atn        = (ieee_atn_i == ASSERT);
    assign acc_active = listen || atn;

    assign tx_pop  = ce && !ifc && !atn && (src_state == S_DAV) && (ieee_ndac_i == REL);
    assign rx_push = ce && !ifc && acc_active && (acc_state == A_RDY) && (ieee_dav_i == ASSERT);

    ieee488_fifo #(.WIDTH(TX_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .clear(ifc),
        .push(tx_valid && tx_ready), .push_data({tx_eoi, tx_data}),
        .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty)
    );

    ieee488_fifo #(.WIDTH(RX_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .clear(ifc),
        .push(rx_push), .push_data({~ieee_atn_i, ~ieee_eoi_i, ~ieee_data_i}),
        .pop(rx_ready), .pop_data(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_word  = rx_empty ? '0 : rx_head;
    assign rx_data  = rx_word[7:0];
    assign rx_eoi   = rx_word[8];
    assign rx_atn   = rx_word[9];

    always_ff @(posedge clk) begin
        if (reset || ifc) begin
            src_state   <= S_IDLE;
            ieee_dav_o  <= REL;
            ieee_data_o <= 8'hFF;
            ieee_eoi_o  <= REL;
            timeout     <= 1'b0;
            no_listener <= 1'b0;
            settle_cnt  <= SETTLE_LOAD;
            tmo_cnt     <= TMO_LOAD;
        end else if (ce) begin
            // Counter only runs while parked in a handshake wait state.
            if (src_state == S_WRFD || src_state == S_DAV)
                tmo_cnt <= tmo_cnt - TW'(1);
            else
                tmo_cnt <= TMO_LOAD;

            if (atn) begin
                src_state   <= S_IDLE;
                ieee_dav_o  <= REL;
                ieee_data_o <= 8'hFF;
                ieee_eoi_o  <= REL;
            end else begin
                case (src_state)
                    S_IDLE: if (talk && !tx_empty) begin
                        src_state   <= S_WRFD;
                        ieee_data_o <= ~tx_head[7:0];
                        ieee_eoi_o  <= tx_head[8] ? ASSERT : REL;
                    end
                    S_WRFD: if (ieee_nrfd_i == REL && ieee_ndac_i == REL) begin
                        no_listener <= 1'b1;
                        src_state   <= S_IDLE;
                        ieee_data_o <= 8'hFF;
                        ieee_eoi_o  <= REL;
                    end else if (ieee_nrfd_i == REL) begin
                        src_state  <= S_SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else if (tmo_cnt == '0) begin
                        timeout     <= 1'b1;
                        src_state   <= S_IDLE;
                        ieee_data_o <= 8'hFF;
                        ieee_eoi_o  <= REL;
                    end
                    S_SETTLE: if (settle_cnt < SW'(2)) begin
                        src_state  <= S_DAV;
                        ieee_dav_o <= ASSERT;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                    S_DAV: if (ieee_ndac_i == REL) begin
                        timeout     <= 1'b0;
                        no_listener <= 1'b0;
                        src_state   <= S_DONE;
                        ieee_dav_o  <= REL;
                        ieee_data_o <= 8'hFF;
                        ieee_eoi_o  <= REL;
                    end else if (tmo_cnt == '0) begin
                        timeout     <= 1'b1;
                        src_state   <= S_IDLE;
                        ieee_dav_o  <= REL;
                        ieee_data_o <= 8'hFF;
                        ieee_eoi_o  <= REL;
                    end
                    S_DONE:  src_state <= S_IDLE;
                    default: src_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ifc) begin
            acc_state   <= A_IDLE;
            ieee_nrfd_o <= REL;
            ieee_ndac_o <= REL;
        end else if (ce) begin
            if (!acc_active) begin
                acc_state   <= A_IDLE;
                ieee_nrfd_o <= REL;
                ieee_ndac_o <= REL;
            end else begin
                case (acc_state)
                    A_IDLE: begin
                        ieee_ndac_o <= ASSERT;
                        if (rx_full) begin
                            ieee_nrfd_o <= ASSERT;
                        end else begin
                            ieee_nrfd_o <= REL;
                            acc_state   <= A_RDY;
                        end
                    end
                    A_RDY: if (ieee_dav_i == ASSERT) begin
                        ieee_nrfd_o <= ASSERT;
                        acc_state   <= A_ACC;
                    end
                    A_ACC: begin
                        ieee_ndac_o <= REL;
                        acc_state   <= A_WDAVH;
                    end
                    A_WDAVH: if (ieee_dav_i == REL) begin
                        ieee_ndac_o <= ASSERT;
                        acc_state   <= A_IDLE;
                    end
                    default: acc_state <= A_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ieee488_port.sv
// Directed bench for ieee488_port: the bench plays listener or talker on the
// bus side and checks hand-computed bus values and FIFO outputs.
module tb_ieee488_port;
    logic       clk = 1'b0;
    logic       reset, ce, talk, listen;
    logic [7:0] tx_data, rx_data, ieee_data_i, ieee_data_o;
    logic       tx_eoi, tx_valid, tx_ready, rx_eoi, rx_atn, rx_valid, rx_ready;
    logic       ieee_atn_i, ieee_ifc_i, ieee_dav_i, ieee_dav_o, ieee_eoi_i, ieee_eoi_o;
    logic       ieee_nrfd_i, ieee_nrfd_o, ieee_ndac_i, ieee_ndac_o, timeout, no_listener;
    int         checks = 0;
    int         passed = 0;
    int         ce_div = 0;

    ieee488_port #(.DEPTH(4), .SETTLE(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .ce(ce), .talk(talk), .listen(listen),
        .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_atn(rx_atn), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ieee_data_i(ieee_data_i), .ieee_data_o(ieee_data_o),
        .ieee_atn_i(ieee_atn_i), .ieee_ifc_i(ieee_ifc_i),
        .ieee_dav_i(ieee_dav_i), .ieee_dav_o(ieee_dav_o),
        .ieee_eoi_i(ieee_eoi_i), .ieee_eoi_o(ieee_eoi_o),
        .ieee_nrfd_i(ieee_nrfd_i), .ieee_nrfd_o(ieee_nrfd_o),
        .ieee_ndac_i(ieee_ndac_i), .ieee_ndac_o(ieee_ndac_o),
        .timeout(timeout), .no_listener(no_listener)
    );

    always #5 clk = ~clk;

    // ce is high for one clock in three so the FSMs are seen to ignore idle clocks
    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clk);
            ce_div = (ce_div == 2) ? 0 : ce_div + 1;
            ce = (ce_div == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic tick();
        do @(posedge clk); while (ce !== 1'b1);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d, input logic e);
        @(negedge clk);
        tx_data = d; tx_eoi = e; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic listen_byte(output logic [7:0] d, output logic e, output logic ok);
        ok = 1'b0; d = 8'h00; e = 1'b1;
        ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b0;
        for (int i = 0; i < 40 && ieee_dav_o !== 1'b0; i++) tick();
        if (ieee_dav_o !== 1'b0) return;
        d = ieee_data_o; e = ieee_eoi_o;
        ieee_ndac_i = 1'b1;
        for (int i = 0; i < 40 && ieee_dav_o !== 1'b1; i++) tick();
        ieee_ndac_i = 1'b0;
        ok = (ieee_dav_o === 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && ieee_nrfd_o !== 1'b1; i++) tick();
        if (ieee_nrfd_o !== 1'b1) return;
        ieee_data_i = ~d; ieee_eoi_i = ~e;
        tick();
        ieee_dav_i = 1'b0;
        for (int i = 0; i < 20 && ieee_ndac_o !== 1'b1; i++) tick();
        ieee_dav_i = 1'b1; ieee_data_i = 8'hFF; ieee_eoi_i = 1'b1;
        if (ieee_ndac_o !== 1'b1) return;
        for (int i = 0; i < 20 && ieee_ndac_o !== 1'b0; i++) tick();
        ok = (ieee_ndac_o === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        checks++; if ({ieee_dav_o, ieee_eoi_o, ieee_nrfd_o, ieee_ndac_o, ieee_data_o} !== 12'hFFF)
            $display("FAIL reset_bus: got %h want fff", {ieee_dav_o, ieee_eoi_o, ieee_nrfd_o, ieee_ndac_o, ieee_data_o}); else passed++;
        checks++; if ({tx_ready, rx_valid, rx_eoi, rx_atn, timeout, no_listener} !== 6'b100000)
            $display("FAIL reset_flags: got %b want 100000", {tx_ready, rx_valid, rx_eoi, rx_atn, timeout, no_listener}); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    endtask

    task automatic test_loopback();
        logic [7:0] d; logic e, ok;
        push_tx(8'h41, 1'b0);
        push_tx(8'h42, 1'b1);
        checks++; if (tx_ready !== 1'b1) $display("FAIL loop_tx_ready: got %b want 1", tx_ready); else passed++;
        talk = 1'b1;
        listen_byte(d, e, ok);
        checks++; if ({ok, e, d} !== {1'b1, 1'b1, 8'hBE}) $display("FAIL loop_byte1: got ok=%b eoi=%b data=%h want ok=1 eoi=1 data=be", ok, e, d); else passed++;
        listen_byte(d, e, ok);
        checks++; if ({ok, e, d} !== {1'b1, 1'b0, 8'hBD}) $display("FAIL loop_byte2: got ok=%b eoi=%b data=%h want ok=1 eoi=0 data=bd", ok, e, d); else passed++;
        repeat (2) tick();
        checks++; if ({ieee_dav_o, ieee_eoi_o, ieee_data_o, timeout, no_listener, tx_ready} !== {1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1})
            $display("FAIL loop_idle: got dav=%b eoi=%b data=%h tmo=%b nl=%b rdy=%b want 1 1 ff 0 0 1", ieee_dav_o, ieee_eoi_o, ieee_data_o, timeout, no_listener, tx_ready); else passed++;
        talk = 1'b0;
    endtask

    task automatic test_no_listener();
        logic [7:0] d; logic e, ok, saw_dav;
        ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b1;
        push_tx(8'h55, 1'b0);
        talk = 1'b1;
        tick(); tick();
        checks++; if (no_listener !== 1'b1) $display("FAIL nl_flag: got %b want 1", no_listener); else passed++;
        saw_dav = 1'b0;
        repeat (6) begin tick(); if (ieee_dav_o === 1'b0) saw_dav = 1'b1; end
        checks++; if (saw_dav !== 1'b0) $display("FAIL nl_no_dav: got dav seen=%b want 0", saw_dav); else passed++;
        listen_byte(d, e, ok);
        checks++; if ({ok, d} !== {1'b1, 8'hAA}) $display("FAIL nl_retained: got ok=%b data=%h want ok=1 data=aa", ok, d); else passed++;
        tick();
        checks++; if (no_listener !== 1'b0) $display("FAIL nl_cleared: got %b want 0", no_listener); else passed++;
        talk = 1'b0;
    endtask

    task automatic test_atn_receive();
        logic ok;
        tick();
        checks++; if ({ieee_nrfd_o, ieee_ndac_o} !== 2'b11) $display("FAIL atn_inactive: got %b want 11", {ieee_nrfd_o, ieee_ndac_o}); else passed++;
        ieee_atn_i = 1'b0;
        tick();
        checks++; if (ieee_ndac_o !== 1'b0) $display("FAIL atn_ndac: got %b want 0", ieee_ndac_o); else passed++;
        send_byte(8'h28, 1'b0, ok);
        checks++; if (ok !== 1'b1) $display("FAIL atn_handshake: got ok=%b want 1", ok); else passed++;
        checks++; if ({rx_valid, rx_atn, rx_eoi, rx_data} !== {1'b1, 1'b1, 1'b0, 8'h28})
            $display("FAIL atn_rx: got v=%b atn=%b eoi=%b data=%h want 1 1 0 28", rx_valid, rx_atn, rx_eoi, rx_data); else passed++;
        pop_rx();
        checks++; if (rx_valid !== 1'b0) $display("FAIL atn_pop: got %b want 0", rx_valid); else passed++;
        ieee_atn_i = 1'b1;
        tick(); tick();
        checks++; if ({ieee_nrfd_o, ieee_ndac_o} !== 2'b11) $display("FAIL atn_release: got %b want 11", {ieee_nrfd_o, ieee_ndac_o}); else passed++;
    endtask

    task automatic test_atn_abort();
        logic [7:0] d; logic e, ok, saw_dav;
        ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b0;
        push_tx(8'h33, 1'b1);
        talk = 1'b1;
        for (int i = 0; i < 20 && ieee_dav_o !== 1'b0; i++) tick();
        checks++; if (ieee_dav_o !== 1'b0) $display("FAIL abort_dav: got %b want 0", ieee_dav_o); else passed++;
        ieee_atn_i = 1'b0;
        tick();
        checks++; if ({ieee_dav_o, ieee_eoi_o, ieee_data_o} !== {1'b1, 1'b1, 8'hFF})
            $display("FAIL abort_release: got dav=%b eoi=%b data=%h want 1 1 ff", ieee_dav_o, ieee_eoi_o, ieee_data_o); else passed++;
        saw_dav = 1'b0;
        repeat (3) begin tick(); if (ieee_dav_o === 1'b0) saw_dav = 1'b1; end
        checks++; if (saw_dav !== 1'b0) $display("FAIL abort_hold: got dav seen=%b want 0", saw_dav); else passed++;
        ieee_atn_i = 1'b1;
        listen_byte(d, e, ok);
        checks++; if ({ok, e, d} !== {1'b1, 1'b0, 8'hCC}) $display("FAIL abort_resend: got ok=%b eoi=%b data=%h want 1 0 cc", ok, e, d); else passed++;
        talk = 1'b0;
        checks++; if (rx_valid !== 1'b0) $display("FAIL abort_rx_empty: got %b want 0", rx_valid); else passed++;
    endtask

    task automatic test_rx_full();
        logic ok;
        logic [7:0] exp;
        listen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h10 + 8'(i), 1'b0, ok);
            checks++; if (ok !== 1'b1) $display("FAIL full_send%0d: got ok=%b want 1", i, ok); else passed++;
        end
        send_byte(8'h14, 1'b1, ok);
        checks++; if ({ok, ieee_nrfd_o} !== 2'b00) $display("FAIL full_stall: got ok=%b nrfd=%b want 0 0", ok, ieee_nrfd_o); else passed++;
        checks++; if (rx_data !== 8'h10) $display("FAIL full_head: got %h want 10", rx_data); else passed++;
        pop_rx();
        send_byte(8'h14, 1'b1, ok);
        checks++; if (ok !== 1'b1) $display("FAIL full_resume: got ok=%b want 1", ok); else passed++;
        for (int i = 1; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            checks++; if ({rx_valid, rx_eoi, rx_data} !== {1'b1, 1'b0, exp})
                $display("FAIL full_pop%0d: got v=%b eoi=%b data=%h want 1 0 %h", i, rx_valid, rx_eoi, rx_data, exp); else passed++;
            pop_rx();
        end
        checks++; if ({rx_valid, rx_eoi, rx_atn, rx_data} !== {1'b1, 1'b1, 1'b0, 8'h14})
            $display("FAIL full_fifth: got v=%b eoi=%b atn=%b data=%h want 1 1 0 14", rx_valid, rx_eoi, rx_atn, rx_data); else passed++;
        listen = 1'b0;
    endtask

    task automatic test_timeout_ifc();
        logic saw_dav;
        ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b0;
        push_tx(8'h77, 1'b0);
        talk = 1'b1;
        for (int i = 0; i < 20 && ieee_dav_o !== 1'b0; i++) tick();
        checks++; if (ieee_dav_o !== 1'b0) $display("FAIL tmo_dav: got %b want 0", ieee_dav_o); else passed++;
        repeat (7) tick();
        checks++; if ({timeout, ieee_dav_o} !== 2'b00) $display("FAIL tmo_early: got tmo=%b dav=%b want 0 0", timeout, ieee_dav_o); else passed++;
        tick();
        checks++; if ({timeout, ieee_dav_o, ieee_data_o} !== {1'b1, 1'b1, 8'hFF})
            $display("FAIL tmo_fire: got tmo=%b dav=%b data=%h want 1 1 ff", timeout, ieee_dav_o, ieee_data_o); else passed++;
        ieee_ifc_i = 1'b0;
        tick();
        ieee_ifc_i = 1'b1;
        checks++; if ({timeout, rx_valid, tx_ready} !== 3'b001) $display("FAIL ifc_clear: got tmo=%b rxv=%b rdy=%b want 0 0 1", timeout, rx_valid, tx_ready); else passed++;
        saw_dav = 1'b0;
        repeat (12) begin tick(); if (ieee_dav_o === 1'b0) saw_dav = 1'b1; end
        checks++; if (saw_dav !== 1'b0) $display("FAIL ifc_tx_empty: got dav seen=%b want 0", saw_dav); else passed++;
        talk = 1'b0;
    endtask

    initial begin
        reset = 1'b1; talk = 1'b0; listen = 1'b0;
        tx_data = 8'h00; tx_eoi = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0;
        ieee_data_i = 8'hFF; ieee_atn_i = 1'b1; ieee_ifc_i = 1'b1; ieee_dav_i = 1'b1;
        ieee_eoi_i = 1'b1; ieee_nrfd_i = 1'b1; ieee_ndac_i = 1'b1;
        test_reset();
        test_loopback();
        test_no_listener();
        test_atn_receive();
        test_atn_abort();
        test_rx_full();
        test_timeout_ifc();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
